modexp_ctrl: RTL and testbench

Sequencer that computes `result = msg^exp mod modulus` by right-to-left square-and-multiply. It owns one `mod` reduction unit, driving its 129-bit operand ports and its go/done handshake. The 64x64 products feeding each reduction are formed inside this block. It sits between the RSA top level, which supplies message, key exponent and modulus, and the shared `mod` datapath.

---
 rtl/modexp_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer for msg^exp mod modulus.
// Drives one shared reduction unit through a go/done level handshake.
module modexp_ctrl #(
    parameter int BITS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [BITS-1:0]   msg,
    input  logic [BITS-1:0]   exp,
    input  logic [BITS-1:0]   modulus,
    output logic [BITS-1:0]   result,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2*BITS:0]   mod_x,
    output logic [2*BITS:0]   mod_y,
    output logic              mod_go,
    input  logic [BITS-1:0]   mod_r,
    input  logic              mod_done,
    output logic [2:0]        o_dbg_state
);

    // Reduction handshake: mod_go rises only after mod_done has been seen low;
    // mod_x/mod_y stay constant while mod_go is high; mod_r is taken on the
    // first cycle mod_done is high; mod_go then drops and is held low until
    // mod_done falls.
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RELEASE, S_STEP, S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        OP_REDUCE, OP_MUL, OP_SQR
    } op_t;

    state_t            r_state, w_state_nxt;
    op_t               r_op, w_op_nxt;
    logic [BITS-1:0]   r_acc, w_acc_nxt;
    logic [BITS-1:0]   r_base, w_base_nxt;
    logic [BITS-1:0]   r_e, w_e_nxt;
    logic [BITS-1:0]   r_n, w_n_nxt;
    logic [BITS-1:0]   r_result, w_result_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              r_mod_go, w_mod_go_nxt;
    logic [2*BITS:0]   r_mod_x, w_mod_x_nxt;
    logic [2*BITS:0]   r_mod_y, w_mod_y_nxt;

    logic [BITS-1:0]   w_e_shift;
    logic              w_issue_mul;
    logic [2*BITS-1:0] w_mul_a_ext;
    logic [2*BITS-1:0] w_mul_b_ext;
    logic [2*BITS-1:0] w_prod;

    // One multiplier: acc*base when a MUL is due on this bit, base*base otherwise.
    assign w_e_shift   = r_e >> 1;
    assign w_issue_mul = (r_op != OP_MUL) && r_e[0];
    assign w_mul_a_ext = {{BITS{1'b0}}, (w_issue_mul ? r_acc : r_base)};
    assign w_mul_b_ext = {{BITS{1'b0}}, r_base};
    assign w_prod      = w_mul_a_ext * w_mul_b_ext;

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_acc_nxt    = r_acc;
        w_base_nxt   = r_base;
        w_e_nxt      = r_e;
        w_n_nxt      = r_n;
        w_result_nxt = r_result;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_err_nxt    = r_err;
        w_mod_go_nxt = r_mod_go;
        w_mod_x_nxt  = r_mod_x;
        w_mod_y_nxt  = r_mod_y;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_nxt   = {{(BITS-1){1'b0}}, 1'b1};
                    w_base_nxt  = msg;
                    w_e_nxt     = exp;
                    w_n_nxt     = modulus;
                    w_busy_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                // A zero divisor would hang the reduction unit, so it is trapped here.
                if (r_n == '0) begin
                    w_err_nxt    = 1'b1;
                    w_result_nxt = '0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_FINISH;
                end else if (r_n == {{(BITS-1){1'b0}}, 1'b1}) begin
                    w_result_nxt = '0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_FINISH;
                end else if (r_e == '0) begin
                    w_result_nxt = {{(BITS-1){1'b0}}, 1'b1};
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_FINISH;
                end else begin
                    w_op_nxt    = OP_REDUCE;
                    w_mod_y_nxt = {{(BITS+1){1'b0}}, r_base};
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_mod_x_nxt  = {{(BITS+1){1'b0}}, r_n};
                w_mod_go_nxt = 1'b1;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (mod_done) begin
                    if (r_op == OP_MUL) begin
                        w_acc_nxt = mod_r;
                    end else begin
                        w_base_nxt = mod_r;
                    end
                    w_mod_go_nxt = 1'b0;
                    w_state_nxt  = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!mod_done) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                if (w_issue_mul) begin
                    w_op_nxt    = OP_MUL;
                    w_mod_y_nxt = {1'b0, w_prod};
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_e_nxt = w_e_shift;
                    if (w_e_shift != '0) begin
                        w_op_nxt    = OP_SQR;
                        w_mod_y_nxt = {1'b0, w_prod};
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_result_nxt = r_acc;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_done_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_REDUCE;
            r_acc    <= '0;
            r_base   <= '0;
            r_e      <= '0;
            r_n      <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_mod_go <= 1'b0;
            r_mod_x  <= '0;
            r_mod_y  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_acc    <= w_acc_nxt;
            r_base   <= w_base_nxt;
            r_e      <= w_e_nxt;
            r_n      <= w_n_nxt;
            r_result <= w_result_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_mod_go <= w_mod_go_nxt;
            r_mod_x  <= w_mod_x_nxt;
            r_mod_y  <= w_mod_y_nxt;
        end
    end

    assign result      = r_result;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign mod_go      = r_mod_go;
    assign mod_x       = r_mod_x;
    assign mod_y       = r_mod_y;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural reduction unit, arithmetic reference
// model of the operation sequence, and directed plus randomized runs.
module tb_modexp_ctrl;

    localparam int BITS = 64;
    localparam int YW   = 2*BITS+1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [BITS-1:0] msg = '0;
    logic [BITS-1:0] exp = '0;
    logic [BITS-1:0] modulus = '0;
    logic [BITS-1:0] result;
    logic            busy;
    logic            done;
    logic            err;
    logic [YW-1:0]   mod_x;
    logic [YW-1:0]   mod_y;
    logic            mod_go;
    logic [BITS-1:0] mod_r = '0;
    logic            mod_done = 1'b0;
    logic [2:0]      dbg_state;

    int checks = 0;
    int errors = 0;

    logic [YW-1:0]   exp_q[$];
    int              op_cnt = 0;
    logic [BITS-1:0] cur_n = '0;
    bit              slow = 1'b0;
    logic [BITS-1:0] first_rem = '0;

    int              ph = 0;
    int              lat = 0;
    int              hold = 0;
    logic [YW-1:0]   cap_x = '0;
    logic [YW-1:0]   cap_y = '0;
    logic [YW-1:0]   ey = '0;

    modexp_ctrl #(.BITS(BITS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .msg(msg), .exp(exp), .modulus(modulus),
        .result(result), .busy(busy), .done(done), .err(err),
        .mod_x(mod_x), .mod_y(mod_y), .mod_go(mod_go),
        .mod_r(mod_r), .mod_done(mod_done), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [BITS-1:0] mulmod(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                               input logic [BITS-1:0] n);
        logic [2*BITS-1:0] p;
        logic [2*BITS-1:0] r;
        p = {64'b0, a} * {64'b0, b};
        r = p % {64'b0, n};
        return r[BITS-1:0];
    endfunction

    // Fills exp_q with the dividend of every reduction, in order.
    task automatic model(input logic [BITS-1:0] m, input logic [BITS-1:0] e, input logic [BITS-1:0] n,
                         output logic [BITS-1:0] res, output logic er, output int nops);
        logic [BITS-1:0]   acc;
        logic [BITS-1:0]   base;
        logic [2*BITS-1:0] p;
        int                msb;
        exp_q.delete();
        nops = 0;
        er   = 1'b0;
        res  = '0;
        if (n == 0) begin
            er = 1'b1;
        end else if (n == 1) begin
            res = '0;
        end else if (e == 0) begin
            res = 1;
        end else begin
            exp_q.push_back({65'b0, m});
            nops = 1;
            base = m % n;
            acc  = 1;
            msb  = 0;
            for (int i = 0; i < BITS; i++) if (e[i]) msb = i;
            for (int i = 0; i <= msb; i++) begin
                if (e[i]) begin
                    p = {64'b0, acc} * {64'b0, base};
                    exp_q.push_back({1'b0, p});
                    acc = mulmod(acc, base, n);
                    nops++;
                end
                if (i < msb) begin
                    p = {64'b0, base} * {64'b0, base};
                    exp_q.push_back({1'b0, p});
                    base = mulmod(base, base, n);
                    nops++;
                end
            end
            res = acc;
        end
    endtask

    // ---------------- reduction unit model + scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mod_done = 1'b0;
                ph = 0;
                continue;
            end
            case (ph)
                0: begin
                    if (mod_go) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL op_extra: mod_y=%0h, no reduction expected", mod_y);
                        end else begin
                            ey = exp_q.pop_front();
                            if (mod_y !== ey) begin
                                errors++;
                                $display("FAIL op_y: op %0d mod_y=%0h expected %0h", op_cnt, mod_y, ey);
                            end
                        end
                        checks++;
                        if (mod_x !== {65'b0, cur_n}) begin
                            errors++;
                            $display("FAIL op_x: mod_x=%0h expected %0h", mod_x, {65'b0, cur_n});
                        end
                        checks++;
                        if (mod_y[YW-1] !== 1'b0) begin
                            errors++;
                            $display("FAIL op_y_range: mod_y=%0h exceeds 2^128-1", mod_y);
                        end
                        cap_x = mod_x;
                        cap_y = mod_y;
                        op_cnt++;
                        lat = slow ? 6 : $urandom_range(1, 4);
                        ph = 1;
                    end
                end
                1: begin
                    checks++;
                    if (mod_go !== 1'b1 || mod_x !== cap_x || mod_y !== cap_y) begin
                        errors++;
                        $display("FAIL op_hold: go=%0b x=%0h y=%0h while waiting, expected go=1 x=%0h y=%0h",
                                 mod_go, mod_x, mod_y, cap_x, cap_y);
                    end
                    lat--;
                    if (lat == 0) begin
                        mod_r = (cap_x == 0) ? '0 : BITS'(cap_y % cap_x);
                        if (op_cnt == 1) first_rem = mod_r;
                        mod_done = 1'b1;
                        ph = 2;
                    end
                end
                2: begin
                    if (!mod_go) begin
                        hold = $urandom_range(0, 2);
                        ph = 3;
                    end else begin
                        checks++;
                        if (mod_x !== cap_x || mod_y !== cap_y) begin
                            errors++;
                            $display("FAIL op_hold_done: x=%0h y=%0h expected x=%0h y=%0h",
                                     mod_x, mod_y, cap_x, cap_y);
                        end
                    end
                end
                default: begin
                    checks++;
                    if (mod_go !== 1'b0) begin
                        errors++;
                        $display("FAIL go_with_done: mod_go=%0b while mod_done high, expected 0", mod_go);
                    end
                    if (hold == 0) begin
                        mod_done = 1'b0;
                        ph = 0;
                    end else begin
                        hold--;
                    end
                end
            endcase
        end
    end

    // ---------------- driver ----------------
    task automatic do_run(input logic [BITS-1:0] m, input logic [BITS-1:0] e, input logic [BITS-1:0] n,
                          input bit poke, input string tag);
        logic [BITS-1:0] eres;
        logic            eerr;
        int              nops;
        int              cyc;
        model(m, e, n, eres, eerr, nops);
        op_cnt = 0;
        cur_n  = n;
        @(negedge clk);
        msg = m; exp = e; modulus = n; start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 1);
            if (cyc == 1) begin
                msg     = {$urandom, $urandom};
                exp     = {$urandom, $urandom};
                modulus = {$urandom, $urandom};
                checks++;
                if (busy !== 1'b1 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s accept: busy=%0b err=%0b expected busy=1 err=0", tag, busy, err);
                end
            end
        end while (done !== 1'b1 && cyc < 20000);
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%0b after %0d cycles, expected 1", tag, done, cyc);
        end else begin
            checks++;
            if (result !== eres) begin
                errors++;
                $display("FAIL %s result: got %0d expected %0d", tag, result, eres);
            end
            checks++;
            if (err !== eerr) begin
                errors++;
                $display("FAIL %s err: got %0b expected %0b", tag, err, eerr);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_at_done: got %0b expected 1", tag, busy);
            end
            checks++;
            if (op_cnt !== nops || exp_q.size() != 0) begin
                errors++;
                $display("FAIL %s op_count: got %0d (left %0d) expected %0d", tag, op_cnt, exp_q.size(), nops);
            end
            if (n <= 1 || e == 0) begin
                checks++;
                if (cyc !== 2) begin
                    errors++;
                    $display("FAIL %s shortcut_latency: done at %0d clocks after start edge, expected 2", tag, cyc);
                end
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s after_done: done=%0b busy=%0b expected 0 0", tag, done, busy);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            mod_go !== 1'b0 || mod_x !== '0 || mod_y !== '0) begin
            errors++;
            $display("FAIL %s: result=%0h busy=%0b done=%0b err=%0b go=%0b x=%0h y=%0h expected all 0",
                     tag, result, busy, done, err, mod_go, mod_x, mod_y);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_vectors;
        do_run(64'd4, 64'd13, 64'd497, 1'b0, "v4_13_497");
        checks++;
        if (result !== 64'd445 || op_cnt !== 7) begin
            errors++;
            $display("FAIL v4_13_497_known: result=%0d ops=%0d expected 445 and 7", result, op_cnt);
        end
        do_run(64'd10, 64'd3, 64'd7, 1'b0, "v10_3_7");
        checks++;
        if (first_rem !== 64'd3 || result !== 64'd6) begin
            errors++;
            $display("FAIL v10_3_7_known: reduce=%0d result=%0d expected 3 and 6", first_rem, result);
        end
    endtask

    task automatic test_shortcuts;
        do_run(64'd5, 64'd0, 64'd7, 1'b0, "exp_zero");
        checks++;
        if (result !== 64'd1 || op_cnt !== 0) begin
            errors++;
            $display("FAIL exp_zero_known: result=%0d ops=%0d expected 1 and 0", result, op_cnt);
        end
        do_run(64'd5, 64'd5, 64'd1, 1'b1, "mod_one");
        checks++;
        if (result !== 64'd0 || op_cnt !== 0) begin
            errors++;
            $display("FAIL mod_one_known: result=%0d ops=%0d expected 0 and 0", result, op_cnt);
        end
    endtask

    task automatic test_zero_mod;
        do_run(64'd9, 64'd5, 64'd0, 1'b0, "mod_zero");
        checks++;
        if (err !== 1'b1 || result !== 64'd0 || op_cnt !== 0) begin
            errors++;
            $display("FAIL mod_zero_known: err=%0b result=%0d ops=%0d expected 1 0 0", err, result, op_cnt);
        end
        do_run(64'd4, 64'd13, 64'd497, 1'b0, "err_clear");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_known: err=%0b expected 0", err);
        end
    endtask

    task automatic test_max;
        do_run({64{1'b1}}, {64{1'b1}}, 64'hFFFF_FFFF_FFFF_FFC5, 1'b0, "max_operands");
    endtask

    task automatic test_back_to_back;
        logic [BITS-1:0] m;
        logic [BITS-1:0] e;
        logic [BITS-1:0] n;
        for (int k = 0; k < 64; k++) begin
            m = {$urandom, $urandom};
            e = {$urandom, $urandom} >> $urandom_range(0, 63);
            n = {$urandom, $urandom} >> $urandom_range(0, 62);
            if (n < 2) n = n + 2;
            do_run(m, e, n, (k % 4) == 0, "random");
        end
    endtask

    task automatic test_reset_mid;
        logic [BITS-1:0] eres;
        logic            eerr;
        int              nops;
        int              cyc;
        model(64'd4, 64'd13, 64'd497, eres, eerr, nops);
        op_cnt = 0;
        cur_n  = 64'd497;
        slow   = 1'b1;
        @(negedge clk);
        msg = 64'd4; exp = 64'd13; modulus = 64'd497; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(op_cnt == 2 && mod_go === 1'b1) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL reset_mid_reach: ops=%0d go=%0b, expected 2nd reduction in flight", op_cnt, mod_go);
        end
        #2 reset_n = 1'b0;
        #1 check_reset_values("reset_mid_async");
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        slow = 1'b0;
        reset_n = 1'b1;
        do_run(64'd4, 64'd13, 64'd497, 1'b0, "after_reset_mid");
        checks++;
        if (result !== 64'd445) begin
            errors++;
            $display("FAIL after_reset_mid_known: result=%0d expected 445", result);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_shortcuts();
        test_zero_mod();
        test_max();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
